// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and defaults for the register-file port arbiter.
// The slot-tag owner field is sized for the largest supported requester count (8).
package regfile_pkg;

    localparam int RF_M    = 32;
    localparam int RF_N    = 32;
    localparam int OWNER_W = 3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic               vld;
        logic [OWNER_W-1:0] owner;
        logic               byp;
    } slot_tag_t;

    // (base + off) mod modn, valid while both operands are below modn.
    function automatic int wrap_add(input int base, input int off, input int modn);
        int s;
        s = base + off;
        return (s >= modn) ? (s - modn) : s;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter: packed per-requester
// request lanes plus the one-cycle-late read response.
interface regfile_port_arbiter_if #(
    parameter int M    = 32,
    parameter int N    = 32,
    parameter int NREQ = 4
);
    localparam int AW = $clog2(M);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*N-1:0]  req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [N-1:0]       resp_data;
    logic [N-1:0]       resp_data2;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_data2
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_data2
    );

endinterface

// File: rtl/regfile_port_arbiter_rr_scan.sv
// Combinational round-robin finder: first and second set bits of a mask,
// scanning from i_ptr upward modulo NREQ, with their scan offsets.
module rr_scan
    import regfile_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_mask,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic                    o_first_vld,
    output logic [$clog2(NREQ)-1:0] o_first_idx,
    output logic [$clog2(NREQ)-1:0] o_first_off,
    output logic                    o_second_vld,
    output logic [$clog2(NREQ)-1:0] o_second_idx,
    output logic [$clog2(NREQ)-1:0] o_second_off
);
    localparam int IW = $clog2(NREQ);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_first_vld  = 1'b0;
        o_first_idx  = '0;
        o_first_off  = '0;
        o_second_vld = 1'b0;
        o_second_idx = '0;
        o_second_off = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (i_mask[wrap_add(int'(i_ptr), k, NREQ)]) begin
                if (!o_first_vld) begin
                    o_first_vld = 1'b1;
                    o_first_idx = IW'(wrap_add(int'(i_ptr), k, NREQ));
                    o_first_off = IW'(k);
                end else if (!o_second_vld) begin
                    o_second_vld = 1'b1;
                    o_second_idx = IW'(wrap_add(int'(i_ptr), k, NREQ));
                    o_second_off = IW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a 2-read/1-write register file among NREQ requesters after a zero sweep.
// Optional feature: define RF_WR_BYPASS_EN to forward same-cycle write data to reads.
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int M    = RF_M,
    parameter int N    = RF_N,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_port_arbiter_if.slave bus,
    output logic                 init_done,
    output logic                 rf_we,
    output logic [$clog2(M)-1:0] rf_rw,
    output logic [N-1:0]         rf_data_in,
    output logic [$clog2(M)-1:0] rf_r1,
    output logic [$clog2(M)-1:0] rf_r2,
    input  logic [N-1:0]         rf_q1,
    input  logic [N-1:0]         rf_q2
);
    localparam int AW = $clog2(M);
    localparam int IW = $clog2(NREQ);

    arb_state_t      r_state, w_state_nxt;
    logic [AW-1:0]   r_init_cnt, w_init_cnt_nxt;
    logic            r_init_done, w_init_done_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    slot_tag_t       r_tag0, r_tag1, w_tag0_nxt, w_tag1_nxt;
    logic [IW-1:0]   w_max_off;

    logic            w_run;
    logic [NREQ-1:0] w_wr_mask, w_rd_mask;
    logic            w_wr_vld, w_rd0_vld, w_rd1_vld;
    logic [IW-1:0]   w_wr_idx, w_wr_off, w_rd0_idx, w_rd0_off, w_rd1_idx, w_rd1_off;
    logic            w_unused_wr2_vld;
    logic [IW-1:0]   w_unused_wr2_idx, w_unused_wr2_off;

    assign w_run     = (r_state == RUN);
    assign w_wr_mask = bus.req_valid &  bus.req_we & {NREQ{w_run}};
    assign w_rd_mask = bus.req_valid & ~bus.req_we & {NREQ{w_run}};

    rr_scan #(.NREQ(NREQ)) u_wr_scan (
        .i_mask       (w_wr_mask),
        .i_ptr        (r_ptr),
        .o_first_vld  (w_wr_vld),
        .o_first_idx  (w_wr_idx),
        .o_first_off  (w_wr_off),
        .o_second_vld (w_unused_wr2_vld),
        .o_second_idx (w_unused_wr2_idx),
        .o_second_off (w_unused_wr2_off)
    );

    rr_scan #(.NREQ(NREQ)) u_rd_scan (
        .i_mask       (w_rd_mask),
        .i_ptr        (r_ptr),
        .o_first_vld  (w_rd0_vld),
        .o_first_idx  (w_rd0_idx),
        .o_first_off  (w_rd0_off),
        .o_second_vld (w_rd1_vld),
        .o_second_idx (w_rd1_idx),
        .o_second_off (w_rd1_off)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_init_cnt_nxt  = r_init_cnt;
        w_init_done_nxt = r_init_done;
        w_ptr_nxt       = r_ptr;
        w_tag0_nxt      = '0;
        w_tag1_nxt      = '0;
        w_max_off       = '0;
        bus.req_ready   = '0;
        rf_we           = 1'b0;
        rf_rw           = '0;
        rf_data_in      = '0;
        rf_r1           = '0;
        rf_r2           = '0;
        case (r_state)
            INIT: begin
                rf_we = 1'b1;
                rf_rw = r_init_cnt;
                if (r_init_cnt == AW'(M - 1)) begin
                    w_state_nxt     = RUN;
                    w_init_done_nxt = 1'b1;
                    w_init_cnt_nxt  = '0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            RUN: begin
                if (w_wr_vld) begin
                    bus.req_ready[w_wr_idx] = 1'b1;
                    rf_we      = 1'b1;
                    rf_rw      = bus.req_addr[w_wr_idx*AW +: AW];
                    rf_data_in = bus.req_wdata[w_wr_idx*N +: N];
                    w_max_off  = w_wr_off;
                end
                if (w_rd0_vld) begin
                    bus.req_ready[w_rd0_idx] = 1'b1;
                    rf_r1      = bus.req_addr[w_rd0_idx*AW +: AW];
                    w_tag0_nxt = '{vld: 1'b1, owner: OWNER_W'(w_rd0_idx), byp: 1'b0};
`ifdef RF_WR_BYPASS_EN
                    w_tag0_nxt.byp = w_wr_vld && (rf_rw == rf_r1);
`endif
                    if (w_rd0_off > w_max_off) w_max_off = w_rd0_off;
                end
                if (w_rd1_vld) begin
                    bus.req_ready[w_rd1_idx] = 1'b1;
                    rf_r2      = bus.req_addr[w_rd1_idx*AW +: AW];
                    w_tag1_nxt = '{vld: 1'b1, owner: OWNER_W'(w_rd1_idx), byp: 1'b0};
`ifdef RF_WR_BYPASS_EN
                    w_tag1_nxt.byp = w_wr_vld && (rf_rw == rf_r2);
`endif
                    if (w_rd1_off > w_max_off) w_max_off = w_rd1_off;
                end
                // Pointer moves just past the furthest granted requester in scan order.
                if (w_wr_vld || w_rd0_vld)
                    w_ptr_nxt = IW'(wrap_add(int'(r_ptr), int'(w_max_off) + 1, NREQ));
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their next values from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_ptr       <= '0;
            r_tag0      <= '0;
            r_tag1      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
            r_init_done <= w_init_done_nxt;
            r_ptr       <= w_ptr_nxt;
            r_tag0      <= w_tag0_nxt;
            r_tag1      <= w_tag1_nxt;
        end
    end

    assign init_done = r_init_done;

    always_comb begin
        bus.resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((r_tag0.vld && r_tag0.owner == OWNER_W'(i)) ||
                (r_tag1.vld && r_tag1.owner == OWNER_W'(i)))
                bus.resp_valid[i] = 1'b1;
        end
    end

`ifdef RF_WR_BYPASS_EN
    logic [N-1:0] r_byp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_byp_data <= '0;
        else if (rf_we)
            r_byp_data <= rf_data_in;
    end

    assign bus.resp_data  = !r_tag0.vld ? '0 : (r_tag0.byp ? r_byp_data : rf_q1);
    assign bus.resp_data2 = !r_tag1.vld ? '0 : (r_tag1.byp ? r_byp_data : rf_q2);
`else
    logic w_unused_byp;

    assign w_unused_byp   = r_tag0.byp | r_tag1.byp;
    assign bus.resp_data  = r_tag0.vld ? rf_q1 : '0;
    assign bus.resp_data2 = r_tag1.vld ? rf_q2 : '0;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural register file and
// a response scoreboard drained by an independent monitor.
module tb_regfile_port_arbiter;

    localparam int M    = 32;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_port_arbiter_if #(.M(M), .N(N), .NREQ(NREQ)) bus ();

    logic          init_done, rf_we;
    logic [AW-1:0] rf_rw, rf_r1, rf_r2;
    logic [N-1:0]  rf_data_in, rf_q1, rf_q2;

    regfile_port_arbiter #(.M(M), .N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .init_done  (init_done),
        .rf_we      (rf_we),
        .rf_rw      (rf_rw),
        .rf_data_in (rf_data_in),
        .rf_r1      (rf_r1),
        .rf_r2      (rf_r2),
        .rf_q1      (rf_q1),
        .rf_q2      (rf_q2)
    );

    // Register file macro: registered reads return the pre-write contents.
    logic [N-1:0] mem [M];
    always @(posedge clk) begin
        if (rf_we) mem[rf_rw] <= rf_data_in;
        rf_q1 <= mem[rf_r1];
        rf_q2 <= mem[rf_r2];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           owner;
        logic [N-1:0] data;
        int           due;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_req();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [N-1:0] d);
        bus.req_valid[i]          = 1'b1;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*N +: N]   = d;
    endtask

    task automatic expect_rd(input int owner, input logic [N-1:0] d);
        exp_t e;
        e.owner = owner;
        e.data  = d;
        e.due   = cyc + 1;
        q.push_back(e);
    endtask

    task automatic start();
        @(negedge clk);
        clear_req();
    endtask

    // Called at the negedge where rst_n was released; requests stay asserted throughout.
    task automatic init_sweep();
        for (int k = 0; k < M; k++) begin
            #1;
            check("init_wr", {rf_we, rf_rw}, {1'b1, AW'(k)});
            check("init_quiet", {bus.req_ready, init_done, rf_data_in}, '0);
            @(negedge clk);
        end
        #1;
        clear_req();
        #1;
        check("init_done", {init_done, rf_we}, 2'b10);
    endtask

    // Monitor: pops expectations due this cycle and compares what the DUT presents.
    exp_t            m_e0, m_e1;
    bit              m_h0, m_h1;
    logic [NREQ-1:0] m_exp_v;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                m_h0 = 1'b0;
                m_h1 = 1'b0;
                m_exp_v = '0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    m_e0 = q.pop_front();
                    m_h0 = 1'b1;
                    m_exp_v[m_e0.owner] = 1'b1;
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    m_e1 = q.pop_front();
                    m_h1 = 1'b1;
                    m_exp_v[m_e1.owner] = 1'b1;
                end
                if (m_h0 || bus.resp_valid != '0) begin
                    check("resp_valid", bus.resp_valid, m_exp_v);
                    if (m_h0) check("resp_data", bus.resp_data, m_e0.data);
                    if (m_h1) check("resp_data2", bus.resp_data2, m_e1.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_req();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", {init_done, bus.resp_valid, bus.resp_data, bus.resp_data2}, '0);
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), '0);
        rst_n = 1'b1;
        init_sweep();

        // Single write then read from requester 2.
        start(); set_req(2, 1'b1, 5'd5, 32'hDEADBEEF); #1;
        check("wr_ready", bus.req_ready, 4'b0100);
        check("wr_port", {rf_we, rf_rw, rf_data_in}, {1'b1, 5'd5, 32'hDEADBEEF});
        start(); #1;
        check("idle_ports", {rf_we, rf_r1, rf_r2, bus.req_ready}, '0);
        start(); set_req(2, 1'b0, 5'd5, '0); #1;
        check("rd_ready", bus.req_ready, 4'b0100);
        check("rd_port", {rf_r1, rf_r2}, {5'd5, 5'd0});
        expect_rd(2, 32'hDEADBEEF);

        // Requester 3 seeds addr 7 and brings ptr back to 0.
        start(); set_req(3, 1'b1, 5'd7, 32'h11); #1;
        check("seed_ready", bus.req_ready, 4'b1000);

        // Full read contention.
        for (int c = 0; c < 4; c++) begin
            start();
            set_req(0, 1'b0, 5'd5, '0);
            set_req(1, 1'b0, 5'd7, '0);
            set_req(2, 1'b0, 5'd0, '0);
            set_req(3, 1'b0, 5'd5, '0);
            #1;
            if (c % 2 == 0) begin
                check("cont_ready_01", bus.req_ready, 4'b0011);
                check("cont_addr_01", {rf_r1, rf_r2}, {5'd5, 5'd7});
                expect_rd(0, 32'hDEADBEEF);
                expect_rd(1, 32'h11);
            end else begin
                check("cont_ready_23", bus.req_ready, 4'b1100);
                check("cont_addr_23", {rf_r1, rf_r2}, {5'd0, 5'd5});
                expect_rd(2, 32'h0);
                expect_rd(3, 32'hDEADBEEF);
            end
        end

        // Mixed writes and a read.
        start();
        set_req(1, 1'b1, 5'd9, 32'hAAAA0001);
        set_req(3, 1'b1, 5'd10, 32'h33333333);
        set_req(0, 1'b0, 5'd5, '0);
        #1;
        check("mix_ready", bus.req_ready, 4'b0011);
        check("mix_wr", {rf_we, rf_rw, rf_data_in}, {1'b1, 5'd9, 32'hAAAA0001});
        check("mix_rd", {rf_r1, rf_r2}, {5'd5, 5'd0});
        expect_rd(0, 32'hDEADBEEF);
        start();
        set_req(3, 1'b1, 5'd10, 32'h33333333);
        set_req(1, 1'b1, 5'd11, 32'h55);
        #1;
        check("mix_ptr2_ready", bus.req_ready, 4'b1000);
        check("mix_ptr2_wr", {rf_we, rf_rw}, {1'b1, 5'd10});
        start(); set_req(1, 1'b1, 5'd11, 32'h55); #1;
        check("mix_wrap_ready", bus.req_ready, 4'b0010);
        start();
        set_req(0, 1'b0, 5'd9, '0);
        set_req(1, 1'b0, 5'd10, '0);
        #1;
        check("rb_ready", bus.req_ready, 4'b0011);
        check("rb_addr", {rf_r1, rf_r2}, {5'd9, 5'd10});
        expect_rd(0, 32'hAAAA0001);
        expect_rd(1, 32'h33333333);
        start(); set_req(2, 1'b0, 5'd11, '0); #1;
        check("rb11_ready", bus.req_ready, 4'b0100);
        expect_rd(2, 32'h55);

        // Same-cycle write and read of addr 7 (holds 0x11).
        start();
        set_req(0, 1'b1, 5'd7, 32'h22);
        set_req(1, 1'b0, 5'd7, '0);
        #1;
        check("raw_ready", bus.req_ready, 4'b0011);
`ifdef RF_WR_BYPASS_EN
        expect_rd(1, 32'h22);
`else
        expect_rd(1, 32'h11);
`endif
        start(); set_req(2, 1'b0, 5'd7, '0); #1;
        check("raw_after_ready", bus.req_ready, 4'b0100);
        expect_rd(2, 32'h22);
        start();
        start();

        // Reset asserted in the cycle after a read handshake.
        start(); set_req(1, 1'b0, 5'd5, '0); #1;
        check("rst_rd_ready", bus.req_ready, 4'b0010);
        @(posedge clk); #1;
        check("pre_reset_resp", {bus.resp_valid, bus.resp_data}, {4'b0010, 32'hDEADBEEF});
        rst_n = 1'b0;
        #1;
        check("reset_drop", {bus.resp_valid, bus.resp_data, init_done}, '0);
        check("reset_init", {rf_we, rf_rw}, {1'b1, 5'd0});
        @(negedge clk); clear_req();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i + 5), '0);
        rst_n = 1'b1;
        init_sweep();

        // ptr restarted at 0 and the sweep cleared previously written data.
        start();
        set_req(0, 1'b0, 5'd5, '0);
        set_req(1, 1'b0, 5'd7, '0);
        set_req(2, 1'b0, 5'd9, '0);
        set_req(3, 1'b0, 5'd10, '0);
        #1;
        check("post_rst_ready", bus.req_ready, 4'b0011);
        expect_rd(0, 32'h0);
        expect_rd(1, 32'h0);
        start();
        start();
        start();
        #1;
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
